// File: rtl/readout_sequencer.sv
// Counted, abortable readback of captured samples from sram_interface into the uart.
// One read per word; words with an empty keep mask are dropped without a send.
module readout_sequencer #(
  parameter int MDW     = 32,
  parameter int CW      = 18,
  parameter int TIMEOUT = 1024
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic           start,
  input  logic [CW-1:0]  read_count,
  input  logic           abort,
  output logic           mem_rd_req,
  input  logic           mem_rd_valid,
  input  logic [3:0]     mem_rd_keep,
  input  logic [MDW-1:0] mem_rd_data,
  output logic [MDW-1:0] tx_data,
  output logic [3:0]     tx_keep,
  output logic           tx_send,
  input  logic           tx_busy,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [CW-1:0]  words_sent
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, WAIT_TX, SEND, WAIT_ACK, NEXT} state_t;

  state_t         state, state_d;
  logic [CW-1:0]  remaining, remaining_d, words_sent_d;
  logic [TW-1:0]  timer, timer_d;
  logic [MDW-1:0] tx_data_d;
  logic [3:0]     tx_keep_d;
  logic           mem_rd_req_d, tx_send_d, busy_d, done_d, err_d;
  logic           tmo;

  // Timer only advances while waiting, so hitting the last count means the wait has expired.
  assign tmo = (timer == TW'(TIMEOUT - 1)) &&
               (((state == WAIT_DATA) && !mem_rd_valid) || ((state == WAIT_ACK) && !tx_busy));

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      remaining  <= '0;
      timer      <= '0;
      words_sent <= '0;
      tx_data    <= '0;
      tx_keep    <= '0;
      mem_rd_req <= 1'b0;
      tx_send    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      remaining  <= remaining_d;
      timer      <= timer_d;
      words_sent <= words_sent_d;
      tx_data    <= tx_data_d;
      tx_keep    <= tx_keep_d;
      mem_rd_req <= mem_rd_req_d;
      tx_send    <= tx_send_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (start && (read_count != '0)) state_d = REQ;
      REQ:       state_d = WAIT_DATA;
      WAIT_DATA: if (mem_rd_valid) state_d = (mem_rd_keep == 4'b0000) ? NEXT : WAIT_TX;
                 else if (tmo)     state_d = IDLE;
      WAIT_TX:   if (!tx_busy) state_d = SEND;
      SEND:      state_d = WAIT_ACK;
      WAIT_ACK:  if (tx_busy)  state_d = NEXT;
                 else if (tmo) state_d = IDLE;
      NEXT:      state_d = (remaining <= CW'(1)) ? IDLE : REQ;
      default:   state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Abort freezes the datapath for its cycle: no done, err/words_sent untouched.
  always_comb begin
    remaining_d  = remaining;
    timer_d      = timer;
    words_sent_d = words_sent;
    tx_data_d    = tx_data;
    tx_keep_d    = tx_keep;
    err_d        = err;
    done_d       = 1'b0;
    if (!abort) begin
      case (state)
        IDLE: if (start) begin
          remaining_d  = read_count;
          words_sent_d = '0;
          err_d        = 1'b0;
          done_d       = (read_count == '0);
        end
        REQ:  timer_d = '0;
        WAIT_DATA: begin
          if (mem_rd_valid) begin
            tx_data_d = mem_rd_data;
            tx_keep_d = mem_rd_keep;
          end else if (tmo) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            timer_d = timer + TW'(1);
          end
        end
        SEND: begin
          words_sent_d = words_sent + CW'(1);
          timer_d      = '0;
        end
        WAIT_ACK: if (!tx_busy) begin
          if (tmo) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            timer_d = timer + TW'(1);
          end
        end
        NEXT: begin
          if (remaining != '0) remaining_d = remaining - CW'(1);
          done_d = (remaining == CW'(1));
        end
        default: ;
      endcase
    end
    mem_rd_req_d = (state_d == REQ);
    tx_send_d    = (state_d == SEND);
    busy_d       = (state_d != IDLE);
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Bench for readout_sequencer: sram and uart models, send scoreboard, table of runs
// plus hand-written abort and mid-run reset sequences.
module tb_readout_sequencer;
  localparam int MDW = 32, CW = 18, TO = 16, ULEN = 10;

  logic           sys_clk = 1'b0, sys_rst = 1'b0;
  logic           start = 1'b0, abort = 1'b0;
  logic [CW-1:0]  read_count = '0;
  logic           mem_rd_valid = 1'b0, tx_busy = 1'b0;
  logic [3:0]     mem_rd_keep = '0;
  logic [MDW-1:0] mem_rd_data = '0;
  logic           mem_rd_req, tx_send, busy, done, err;
  logic [MDW-1:0] tx_data;
  logic [3:0]     tx_keep;
  logic [CW-1:0]  words_sent;

  readout_sequencer #(.MDW(MDW), .CW(CW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .read_count(read_count),
    .abort(abort), .mem_rd_req(mem_rd_req), .mem_rd_valid(mem_rd_valid),
    .mem_rd_keep(mem_rd_keep), .mem_rd_data(mem_rd_data), .tx_data(tx_data),
    .tx_keep(tx_keep), .tx_send(tx_send), .tx_busy(tx_busy), .busy(busy),
    .done(done), .err(err), .words_sent(words_sent)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [CW-1:0] rc;
    logic [31:0]   keeps;
    bit            mem_en;
    int            e_req, e_send, e_ws;
    logic          e_err;
    int            e_done_lat;  // 0: not checked
  } vec_t;

  typedef struct packed {
    logic [MDW-1:0] d;
    logic [3:0]     k;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int          nchecks = 0, nerr = 0;
  int          cyc = 0, nreq, nsend, ndone, nvalid, nbusy, lat = 0, ucnt = 0, widx, run_id = 0;
  int          first_req, last_req, done_cyc, start_cyc;
  bit          mem_en;
  logic [31:0] keeps;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: sample DUT outputs just after the edge, then drive model inputs for this cycle.
  task automatic tick();
    exp_t e;
    @(posedge sys_clk); #1;
    cyc++;
    if (busy) nbusy++;
    if (done) begin ndone++; done_cyc = cyc; end
    if (ucnt > 0) begin tx_busy = 1'b1; ucnt--; end
    else tx_busy = 1'b0;
    if (tx_send) begin
      nsend++;
      if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
      else begin
        e = sb.pop_front();
        chk("tx_data", 64'(tx_data), 64'(e.d));
        chk("tx_keep", 64'(tx_keep), 64'(e.k));
      end
      ucnt = ULEN;
    end
    mem_rd_valid = 1'b0;
    if (lat > 0) begin
      lat--;
      if (lat == 0) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = 32'hA500_0000 | (run_id << 8) | widx;
        mem_rd_keep  = keeps[widx*4 +: 4];
        nvalid++;
        if (mem_rd_keep != 4'b0000) sb.push_back('{d: mem_rd_data, k: mem_rd_keep});
        widx++;
      end
    end
    if (mem_rd_req) begin
      nreq++;
      if (first_req < 0) first_req = cyc - start_cyc;
      last_req = cyc;
      if (mem_en) lat = 2;
    end
  endtask

  task automatic begin_run(input logic [CW-1:0] rc, input logic [31:0] kp, input bit en);
    nreq = 0; nsend = 0; ndone = 0; nvalid = 0; nbusy = 0; widx = 0;
    first_req = -1; last_req = -1; done_cyc = -1;
    keeps = kp; mem_en = en; run_id++;
    start = 1'b1; read_count = rc; start_cyc = cyc;
    tick();
    start = 1'b0; read_count = CW'(9);   // later changes must be ignored
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    begin_run(v.rc, v.keeps, v.mem_en);
    for (int i = 0; i < 3000 && ndone == 0; i++) tick();
    repeat (30) tick();
    chk({tag, "_reqs"}, 64'(nreq), 64'(v.e_req));
    chk({tag, "_sends"}, 64'(nsend), 64'(v.e_send));
    chk({tag, "_done_cnt"}, 64'(ndone), 64'd1);
    chk({tag, "_words_sent"}, 64'(words_sent), 64'(v.e_ws));
    chk({tag, "_err"}, 64'(err), 64'(v.e_err));
    chk({tag, "_idle"}, 64'(busy), 64'd0);
    chk({tag, "_sb_left"}, 64'(sb.size()), 64'd0);
    if (v.rc != '0) chk({tag, "_first_req_lat"}, 64'(first_req), 64'd1);
    else            chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd0);
    if (v.e_done_lat != 0)
      chk({tag, "_done_lat"}, 64'(done_cyc - ((last_req < 0) ? start_cyc : last_req)),
          64'(v.e_done_lat));
    sb.delete();
  endtask

  initial begin
    vecs[0] = '{rc: 3, keeps: 32'hFFFF_FFFF, mem_en: 1, e_req: 3, e_send: 3, e_ws: 3, e_err: 0, e_done_lat: 0};
    vecs[1] = '{rc: 4, keeps: 32'h0000_030F, mem_en: 1, e_req: 4, e_send: 2, e_ws: 2, e_err: 0, e_done_lat: 0};
    vecs[2] = '{rc: 0, keeps: 32'hFFFF_FFFF, mem_en: 1, e_req: 0, e_send: 0, e_ws: 0, e_err: 0, e_done_lat: 1};
    vecs[3] = '{rc: 5, keeps: 32'hFFFF_FFFF, mem_en: 0, e_req: 1, e_send: 0, e_ws: 0, e_err: 1, e_done_lat: TO + 1};
    vecs[4] = '{rc: 1, keeps: 32'h0000_000F, mem_en: 1, e_req: 1, e_send: 1, e_ws: 1, e_err: 0, e_done_lat: 0};
    vecs[5] = '{rc: 2, keeps: 32'h0000_00C5, mem_en: 1, e_req: 2, e_send: 2, e_ws: 2, e_err: 0, e_done_lat: 0};

    repeat (2) tick();
    chk("reset_outputs", {mem_rd_req, tx_send, busy, done, err, words_sent, tx_data, tx_keep}, 64'd0);
    sys_rst = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort in WAIT_TX on word 2 of 5, together with a start that must lose.
    begin_run(5, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 500 && nvalid < 2; i++) tick();
    chk("abort_reach_word2", 64'(nvalid), 64'd2);
    tick();
    abort = 1'b1; start = 1'b1; read_count = CW'(3);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_busy_next", 64'(busy), 64'd0);
    repeat (60) tick();
    chk("abort_done_cnt", 64'(ndone), 64'd0);
    chk("abort_reqs", 64'(nreq), 64'd2);
    chk("abort_sends", 64'(nsend), 64'd1);
    chk("abort_words_sent", 64'(words_sent), 64'd1);
    chk("abort_err", 64'(err), 64'd0);
    chk("abort_sb_left", 64'(sb.size()), 64'd1);
    sb.delete();

    // Ignored start while busy, then asynchronous reset while in WAIT_ACK of word 2.
    begin_run(3, 32'hFFFF_FFFF, 1);
    for (int i = 0; i < 500 && nvalid < 1; i++) tick();
    start = 1'b1; read_count = CW'(100);
    tick();
    start = 1'b0;
    for (int i = 0; i < 500 && nsend < 2; i++) tick();
    tick();
    chk("pre_reset_words_sent", 64'(words_sent), 64'd2);
    chk("pre_reset_reqs", 64'(nreq), 64'd2);
    #2 sys_rst = 1'b0;
    #1 chk("async_reset_outputs", {mem_rd_req, tx_send, busy, done, err, words_sent, tx_data, tx_keep}, 64'd0);
    lat = 0; ucnt = 0; tx_busy = 1'b0; mem_rd_valid = 1'b0; sb.delete();
    repeat (2) tick();
    sys_rst = 1'b1;
    tick();
    chk("post_reset_idle", 64'(busy), 64'd0);
    run_vec(vecs[5], "recover");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/readout_sequencer.md
Name: readout_sequencer

Overview:
Sequences readback of captured samples from the SRAM interface into the UART transmitter once a capture completes. Issues one memory read per word, waits for read data, drops words whose channel-group keep mask is empty, and hands each kept word to the UART with a send/busy handshake. Sits between core, sram_interface and uart, replacing the direct memoryRead/outputSend coupling with counted, abortable, timeout-guarded readback.

Parameters:
MDW, 32, memory data width in bits
CW, 18, width of word counters
TIMEOUT, 1024, max cycles to wait for mem_rd_valid or for tx_busy to rise after a send

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse: begin readback
read_count  input  CW  words to read; sampled on start
abort  input  1  cancel readback
mem_rd_req  output  1  one-cycle read request to sram_interface
mem_rd_valid  input  1  read data valid
mem_rd_keep  input  4  per-byte channel-group keep mask
mem_rd_data  input  MDW  read data
tx_data  output  MDW  word presented to uart
tx_keep  output  4  keep mask of tx_data
tx_send  output  1  one-cycle send strobe to uart
tx_busy  input  1  uart busy
busy  output  1  high whenever not IDLE
done  output  1  one-cycle pulse on normal or timeout completion
err  output  1  sticky timeout flag, cleared by next accepted start
words_sent  output  CW  kept words sent in current/last run

Behaviour:
- Reset: state IDLE; all outputs 0; remaining, timer, words_sent 0.
- All outputs registered. States: IDLE, REQ, WAIT_DATA, WAIT_TX, SEND, WAIT_ACK, NEXT.
- IDLE: start with read_count!=0 -> latch remaining=read_count, clear words_sent, clear err, -> REQ. start with read_count==0 -> done pulses next cycle, err cleared, stay IDLE.
- REQ: mem_rd_req=1 for exactly this cycle; timer cleared; -> WAIT_DATA. mem_rd_req first high the cycle after start.
- WAIT_DATA: on mem_rd_valid capture tx_data/tx_keep. keep==4'b0000 -> NEXT (no send, words_sent unchanged); else -> WAIT_TX. Timer increments each cycle without valid; timer==TIMEOUT-1 -> err=1, done pulse, -> IDLE.
- WAIT_TX: tx_busy==0 -> SEND; otherwise hold (no timeout; uart finishing previous word).
- SEND: tx_send=1 one cycle; words_sent+1; timer cleared; -> WAIT_ACK.
- WAIT_ACK: tx_busy==1 -> NEXT; timer at TIMEOUT-1 -> err, done, IDLE.
- NEXT: remaining-1; if it becomes 0 -> done pulse, IDLE; else -> REQ. Next request overlaps the uart transmitting current word.
- abort (any state, any cycle): next state IDLE, mem_rd_req/tx_send forced 0 that cycle, no done pulse, err and words_sent retain values. abort wins over simultaneous start.
- start while busy ignored; read_count changes after start ignored.
- mem_rd_valid outside WAIT_DATA ignored.
- Counters never wrap: remaining only decremented from nonzero; words_sent <= read_count.
- tx_data/tx_keep held stable from capture until the next capture.

Test Plan:
- read_count=3, all keep=4'hF, valid 2 cycles after each req, uart busy 10 cycles per send -> 3 mem_rd_req, 3 tx_send with data in order, words_sent=3, one done, err=0.
- read_count=4, keeps F,0,3,0 -> 4 reqs, 2 tx_send (words 0 and 2, tx_keep F then 3), words_sent=2, done once.
- read_count=0 start -> done pulse one cycle later, no mem_rd_req, busy stays 0.
- read_count=5, memory never asserts valid -> after TIMEOUT cycles err=1, done pulse, IDLE; next start with read_count=1 clears err.
- abort asserted in WAIT_TX on word 2 of 5, same cycle as start -> IDLE next cycle, no done, no further req/send, words_sent=1.
- Reset (sys_rst low) mid-WAIT_ACK -> all outputs 0 immediately, IDLE after release; start pulse during busy run has no effect.
